execute: RTL and testbench



---
 rtl/mips_pkg.sv | 44 ++++
 rtl/muldiv.sv | 110 +++++++++++
 rtl/execute.sv | 142 ++++++++++++++
 tb/tb_execute.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU and mult/div op codes,
// forwarding selects and the mult/div sequencer states.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  localparam logic [2:0] MDOP_NONE  = 3'b000;
  localparam logic [2:0] MDOP_MULT  = 3'b001;
  localparam logic [2:0] MDOP_MULTU = 3'b010;
  localparam logic [2:0] MDOP_DIV   = 3'b011;
  localparam logic [2:0] MDOP_DIVU  = 3'b100;
  localparam logic [2:0] MDOP_MFHI  = 3'b101;
  localparam logic [2:0] MDOP_MFLO  = 3'b110;

  localparam logic [1:0] FWD_ID = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_ME = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIN  = 2'd2
  } mdState_t;

  function automatic logic isMdStartOp(input logic [2:0] op);
    return (op >= MDOP_MULT) && (op <= MDOP_DIVU);
  endfunction

  function automatic logic isMdOp(input logic [2:0] op);
    return (op >= MDOP_MULT) && (op <= MDOP_MFLO);
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step
// per cycle, magnitude arithmetic with a sign fix-up before HI/LO are written.
module muldiv
  import mips_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdState_t    state
);

  localparam int CW = $clog2(MD_ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

  logic [CW-1:0] count;
  logic [63:0]   work;
  logic [31:0]   opB;
  logic [31:0]   rawA;
  logic          isDiv;
  logic          negLo;
  logic          negHi;

  logic          signedOp;
  logic          startDiv;
  logic [31:0]   absA;
  logic [31:0]   absB;
  logic [32:0]   mulSum;
  logic [32:0]   divShift;
  logic          divFits;
  logic [31:0]   divDiff;
  logic [31:0]   divRem;
  logic [63:0]   product;
  logic [31:0]   quotient;
  logic [31:0]   remainder;

  // work holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    signedOp  = (op == MDOP_MULT) || (op == MDOP_DIV);
    startDiv  = (op == MDOP_DIV) || (op == MDOP_DIVU);
    absA      = (signedOp && a[31]) ? 32'd0 - a : a;
    absB      = (signedOp && b[31]) ? 32'd0 - b : b;
    mulSum    = {1'b0, work[63:32]} + (work[0] ? {1'b0, opB} : 33'd0);
    divShift  = {work[63:32], work[31]};
    divFits   = divShift >= {1'b0, opB};
    divDiff   = divShift[31:0] - opB;
    divRem    = divFits ? divDiff : divShift[31:0];
    product   = negLo ? 64'd0 - work : work;
    quotient  = negLo ? 32'd0 - work[31:0] : work[31:0];
    remainder = negHi ? 32'd0 - work[63:32] : work[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      count <= '0;
      work  <= '0;
      opB   <= '0;
      rawA  <= '0;
      isDiv <= 1'b0;
      negLo <= 1'b0;
      negHi <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_RUN;
            count <= '0;
            isDiv <= startDiv;
            rawA  <= a;
            negLo <= signedOp && (a[31] ^ b[31]);
            negHi <= signedOp && startDiv && a[31];
            work  <= {32'd0, startDiv ? absA : absB};
            opB   <= startDiv ? absB : absA;
          end
        end
        MD_RUN: begin
          work  <= isDiv ? {divRem, work[30:0], divFits} : {mulSum, work[31:1]};
          count <= count + CW'(1);
          if (count == LAST) state <= MD_FIN;
        end
        MD_FIN: begin
          if (!isDiv) begin
            {hi, lo} <= product;
          end else if (opB == 32'd0) begin
            hi <= rawA;
            lo <= '1;
          end else begin
            hi <= remainder;
            lo <= quotient;
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state != MD_IDLE);

endmodule

// File: rtl/execute.sv
// MIPS execute stage: operand forwarding, ALU, mult/div unit and the EX
// pipeline registers consumed by the memory stage.
module execute
  import mips_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic [31:0] SrcA_ID,
  input  logic [31:0] SrcB_ID,
  input  logic [31:0] Imm_ID,
  input  logic        ALUSrc_ID,
  input  logic [3:0]  ALUControl_ID,
  input  logic [2:0]  MulDivOp_ID,
  input  logic [1:0]  ForwardA_ID,
  input  logic [1:0]  ForwardB_ID,
  input  logic [31:0] ResultRdDat_ME,
  input  logic        RegWrite_ID,
  input  logic        MemToReg_ID,
  input  logic        MemWrite_ID,
  input  logic        InstrVal_ID,
  input  logic [4:0]  WriteReg_ID,
  output logic [31:0] Result_EX,
  output logic [31:0] WrDat_EX,
  output logic        RegWrite_EX,
  output logic        MemToReg_EX,
  output logic        MemWrite_EX,
  output logic        InstrVal_EX,
  output logic [4:0]  WriteReg_EX,
  output logic        MulDivBusy
);

  logic [31:0] opA;
  logic [31:0] opBFwd;
  logic [31:0] opB;
  logic [4:0]  shamt;
  logic [31:0] aluOut;
  logic [31:0] resultNext;
  logic [31:0] mdHi;
  logic [31:0] mdLo;
  logic        mdBusy;
  logic        mdStart;
  mdState_t    mdState;

  always_comb begin
    case (ForwardA_ID)
      FWD_EX:  opA = Result_EX;
      FWD_ME:  opA = ResultRdDat_ME;
      default: opA = SrcA_ID;
    endcase
    case (ForwardB_ID)
      FWD_EX:  opBFwd = Result_EX;
      FWD_ME:  opBFwd = ResultRdDat_ME;
      default: opBFwd = SrcB_ID;
    endcase
    opB   = ALUSrc_ID ? Imm_ID : opBFwd;
    shamt = Imm_ID[10:6];

    case (ALUControl_ID)
      ALU_AND:  aluOut = opA & opB;
      ALU_OR:   aluOut = opA | opB;
      ALU_ADD:  aluOut = opA + opB;
      ALU_XOR:  aluOut = opA ^ opB;
      ALU_NOR:  aluOut = ~(opA | opB);
      ALU_SUB:  aluOut = opA - opB;
      ALU_SLT:  aluOut = {31'd0, $signed(opA) < $signed(opB)};
      ALU_SLTU: aluOut = {31'd0, opA < opB};
      ALU_SLL:  aluOut = opB << shamt;
      ALU_SRL:  aluOut = opB >> shamt;
      ALU_SRA:  aluOut = $signed(opB) >>> shamt;
      ALU_LUI:  aluOut = {Imm_ID[15:0], 16'd0};
      default:  aluOut = '0;
    endcase

    case (MulDivOp_ID)
      MDOP_MFHI: resultNext = mdHi;
      MDOP_MFLO: resultNext = mdLo;
      default:   resultNext = aluOut;
    endcase
  end

  // MulDivBusy holds the mult/div-class instruction in ID and inserts an EX
  // bubble until the unit is idle; unrelated ALU instructions keep flowing.
  assign mdStart    = (mdState == MD_IDLE) && InstrVal_ID && isMdStartOp(MulDivOp_ID)
                      && !AnyStall && !flush;
  assign MulDivBusy = mdBusy && InstrVal_ID && isMdOp(MulDivOp_ID);

  muldiv #(
    .MD_ITER(MD_ITER)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (mdStart),
    .op    (MulDivOp_ID),
    .a     (opA),
    .b     (opBFwd),
    .busy  (mdBusy),
    .hi    (mdHi),
    .lo    (mdLo),
    .state (mdState)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      Result_EX   <= '0;
      WrDat_EX    <= '0;
      RegWrite_EX <= 1'b0;
      MemToReg_EX <= 1'b0;
      MemWrite_EX <= 1'b0;
      InstrVal_EX <= 1'b0;
      WriteReg_EX <= '0;
    end else if (AnyStall) begin
      Result_EX   <= Result_EX;
      WrDat_EX    <= WrDat_EX;
      RegWrite_EX <= RegWrite_EX;
      MemToReg_EX <= MemToReg_EX;
      MemWrite_EX <= MemWrite_EX;
      InstrVal_EX <= InstrVal_EX;
      WriteReg_EX <= WriteReg_EX;
    end else if (MulDivBusy) begin
      Result_EX   <= '0;
      WrDat_EX    <= '0;
      RegWrite_EX <= 1'b0;
      MemToReg_EX <= 1'b0;
      MemWrite_EX <= 1'b0;
      InstrVal_EX <= 1'b0;
      WriteReg_EX <= '0;
    end else begin
      Result_EX   <= resultNext;
      WrDat_EX    <= opBFwd;
      RegWrite_EX <= RegWrite_ID;
      MemToReg_EX <= MemToReg_ID;
      MemWrite_EX <= MemWrite_ID;
      InstrVal_EX <= InstrVal_ID;
      WriteReg_EX <= WriteReg_ID;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: issued instructions push their
// expected EX word into a queue that a negedge monitor pops and compares.
module tb_execute;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        AnyStall = 1'b0;
  logic [31:0] SrcA_ID = '0;
  logic [31:0] SrcB_ID = '0;
  logic [31:0] Imm_ID = '0;
  logic        ALUSrc_ID = 1'b0;
  logic [3:0]  ALUControl_ID = '0;
  logic [2:0]  MulDivOp_ID = '0;
  logic [1:0]  ForwardA_ID = '0;
  logic [1:0]  ForwardB_ID = '0;
  logic [31:0] ResultRdDat_ME = '0;
  logic        RegWrite_ID = 1'b0;
  logic        MemToReg_ID = 1'b0;
  logic        MemWrite_ID = 1'b0;
  logic        InstrVal_ID = 1'b0;
  logic [4:0]  WriteReg_ID = '0;
  logic [31:0] Result_EX;
  logic [31:0] WrDat_EX;
  logic        RegWrite_EX;
  logic        MemToReg_EX;
  logic        MemWrite_EX;
  logic        InstrVal_EX;
  logic [4:0]  WriteReg_EX;
  logic        MulDivBusy;

  always #5 clk = ~clk;

  execute #(
    .MD_ITER(32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .AnyStall       (AnyStall),
    .SrcA_ID        (SrcA_ID),
    .SrcB_ID        (SrcB_ID),
    .Imm_ID         (Imm_ID),
    .ALUSrc_ID      (ALUSrc_ID),
    .ALUControl_ID  (ALUControl_ID),
    .MulDivOp_ID    (MulDivOp_ID),
    .ForwardA_ID    (ForwardA_ID),
    .ForwardB_ID    (ForwardB_ID),
    .ResultRdDat_ME (ResultRdDat_ME),
    .RegWrite_ID    (RegWrite_ID),
    .MemToReg_ID    (MemToReg_ID),
    .MemWrite_ID    (MemWrite_ID),
    .InstrVal_ID    (InstrVal_ID),
    .WriteReg_ID    (WriteReg_ID),
    .Result_EX      (Result_EX),
    .WrDat_EX       (WrDat_EX),
    .RegWrite_EX    (RegWrite_EX),
    .MemToReg_EX    (MemToReg_EX),
    .MemWrite_EX    (MemWrite_EX),
    .InstrVal_EX    (InstrVal_EX),
    .WriteReg_EX    (WriteReg_EX),
    .MulDivBusy     (MulDivBusy)
  );

  int          nChecks = 0;
  int          nFails = 0;
  logic [71:0] exp_q[$];
  logic        lastHold = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] dutWord();
    return {RegWrite_EX, MemToReg_EX, MemWrite_EX, WriteReg_EX, WrDat_EX, Result_EX};
  endfunction

  function automatic logic [71:0] mkExp(input logic [2:0] md, input logic [4:0] wreg,
                                        input logic [31:0] wr, input logic [31:0] res);
    logic regWrite;
    regWrite = !(md >= 3'd1 && md <= 3'd4);
    return {regWrite, wreg[1], wreg[0], wreg, wr, res};
  endfunction

  task automatic setId(input logic [3:0] alu, input logic [2:0] md, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic src,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] wreg);
    ALUControl_ID = alu;
    MulDivOp_ID   = md;
    SrcA_ID       = a;
    SrcB_ID       = b;
    Imm_ID        = imm;
    ALUSrc_ID     = src;
    ForwardA_ID   = fa;
    ForwardB_ID   = fb;
    WriteReg_ID   = wreg;
    InstrVal_ID   = 1'b1;
    RegWrite_ID   = !(md >= 3'd1 && md <= 3'd4);
    MemToReg_ID   = wreg[1];
    MemWrite_ID   = wreg[0];
  endtask

  task automatic setIdle();
    setId(4'b0000, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 2'd0, 5'd0);
    InstrVal_ID = 1'b0;
    RegWrite_ID = 1'b0;
  endtask

  task automatic idleCycle();
    setIdle();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait out any mult/div stall, then let it load.
  task automatic issue(input string name, input logic [3:0] alu, input logic [2:0] md,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic src, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [4:0] wreg, input logic [31:0] expRes,
                       input logic [31:0] expWr, input int expStall);
    int stalls = 0;
    setId(alu, md, a, b, imm, src, fa, fb, wreg);
    #1;
    while (MulDivBusy && stalls < 100) begin
      @(posedge clk);
      #1;
      stalls++;
      if (stalls == 5) check({name, " bubble"}, {7'd0, InstrVal_EX, dutWord()}, 80'd0);
    end
    check({name, " stall"}, 80'(stalls), 80'(expStall));
    exp_q.push_back(mkExp(md, wreg, expWr, expRes));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) lastHold <= AnyStall && !flush && !reset;

  always @(negedge clk) begin
    if (!reset && InstrVal_EX && !lastHold) begin
      if (exp_q.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected output: got %h, expected none", dutWord());
      end else begin
        check("pipeline output", {8'd0, dutWord()}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // valid ADD held in ID during reset must not reach EX
    setId(4'b0010, 3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 5'd3);
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {7'd0, InstrVal_EX, dutWord()}, 80'd0);
    setIdle();
    reset = 1'b0;
    @(posedge clk);
    #1;

    ResultRdDat_ME = 32'd4;
    issue("fwd seed",     4'b0010, 3'd0, 32'd7,        32'd0,        32'd0,     1'b1, 2'd0, 2'd0, 5'd1, 32'd7,        32'd0,        0);
    issue("fwdA ex add",  4'b0010, 3'd0, 32'd5,        32'd0,        32'd3,     1'b1, 2'd1, 2'd0, 5'd2, 32'd10,       32'd0,        0);
    issue("fwdB me sub",  4'b0110, 3'd0, 32'd20,       32'd99,       32'd0,     1'b0, 2'd0, 2'd2, 5'd3, 32'd16,       32'd4,        0);
    issue("fwd rsvd or",  4'b0001, 3'd0, 32'hF0,       32'h0F,       32'd0,     1'b0, 2'd3, 2'd3, 5'd4, 32'hFF,       32'h0F,       0);
    issue("fwdB ex and",  4'b0000, 3'd0, 32'h1F,       32'd0,        32'd0,     1'b0, 2'd0, 2'd1, 5'd5, 32'h1F,       32'hFF,       0);
    issue("xor",          4'b0011, 3'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0,     1'b0, 2'd0, 2'd0, 5'd6, 32'hF00FF00F, 32'h0F0F0F0F, 0);
    issue("nor",          4'b0100, 3'd0, 32'h0000FFFF, 32'h00FF0000, 32'd0,     1'b0, 2'd0, 2'd0, 5'd7, 32'hFF000000, 32'h00FF0000, 0);
    issue("slt",          4'b0111, 3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,     1'b0, 2'd0, 2'd0, 5'd1, 32'd1,        32'd1,        0);
    issue("sltu",         4'b1000, 3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,     1'b0, 2'd0, 2'd0, 5'd1, 32'd0,        32'd1,        0);
    issue("sll",          4'b1001, 3'd0, 32'd0,        32'd1,        32'h100,   1'b0, 2'd0, 2'd0, 5'd1, 32'h10,       32'd1,        0);
    issue("srl",          4'b1010, 3'd0, 32'd0,        32'hFFFFFF00, 32'h100,   1'b0, 2'd0, 2'd0, 5'd1, 32'h0FFFFFF0, 32'hFFFFFF00, 0);
    issue("sra",          4'b1011, 3'd0, 32'd0,        32'hFFFFFF00, 32'h100,   1'b0, 2'd0, 2'd0, 5'd1, 32'hFFFFFFF0, 32'hFFFFFF00, 0);
    issue("lui",          4'b1100, 3'd0, 32'd0,        32'h55,       32'h1234,  1'b1, 2'd0, 2'd0, 5'd2, 32'h12340000, 32'h55,       0);
    issue("undef alu",    4'b0101, 3'd0, 32'd3,        32'd4,        32'd0,     1'b0, 2'd0, 2'd0, 5'd2, 32'd0,        32'd4,        0);

    issue("mult",         4'b0010, 3'd1, 32'hFFFFFFFD, 32'd7,        32'd0,     1'b0, 2'd0, 2'd0, 5'd8, 32'd4,        32'd7,        0);
    issue("mflo mult",    4'b0010, 3'd6, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'hFFFFFFEB, 32'd0,        33);
    issue("mfhi mult",    4'b0010, 3'd5, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'hFFFFFFFF, 32'd0,        0);

    issue("divu",         4'b0010, 3'd4, 32'd100,      32'd7,        32'd0,     1'b0, 2'd0, 2'd0, 5'd8, 32'd107,      32'd7,        0);
    issue("mflo divu",    4'b0010, 3'd6, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd14,       32'd0,        33);
    issue("mfhi divu",    4'b0010, 3'd5, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd2,        32'd0,        0);

    issue("div",          4'b0010, 3'd3, 32'hFFFFFFF9, 32'd2,        32'd0,     1'b0, 2'd0, 2'd0, 5'd8, 32'hFFFFFFFB, 32'd2,        0);
    issue("mflo div",     4'b0010, 3'd6, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'hFFFFFFFD, 32'd0,        33);
    issue("mfhi div",     4'b0010, 3'd5, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'hFFFFFFFF, 32'd0,        0);

    issue("divu by 0",    4'b0010, 3'd4, 32'd9,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd8, 32'd9,        32'd0,        0);
    issue("mflo div0",    4'b0010, 3'd6, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'hFFFFFFFF, 32'd0,        33);
    issue("mfhi div0",    4'b0010, 3'd5, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd9,        32'd0,        0);

    // flush coincident with a MULT in ID: squashed, unit never starts
    setId(4'b0010, 3'd1, 32'd2, 32'd3, 32'd0, 1'b0, 2'd0, 2'd0, 5'd10);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush outputs", {7'd0, InstrVal_EX, dutWord()}, 80'd0);
    issue("mfhi flush",   4'b0010, 3'd5, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd9,        32'd0,        0);
    issue("mflo flush",   4'b0010, 3'd6, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'hFFFFFFFF, 32'd0,        0);

    // AnyStall for 3 cycles while a MULT runs, with an ADD waiting in ID
    issue("mult stall",   4'b0000, 3'd1, 32'd6,        32'd7,        32'd0,     1'b0, 2'd0, 2'd0, 5'd11, 32'd6,       32'd7,        0);
    setId(4'b0010, 3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 5'd12);
    AnyStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall hold", {7'd0, InstrVal_EX, dutWord()},
            {7'd0, 1'b1, mkExp(3'd1, 5'd11, 32'd7, 32'd6)});
    end
    AnyStall = 1'b0;
    exp_q.push_back(mkExp(3'd0, 5'd12, 32'd2, 32'd3));
    @(posedge clk);
    #1;
    issue("mflo stall",   4'b0010, 3'd6, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd42,       32'd0,        29);
    issue("mfhi stall",   4'b0010, 3'd5, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd0,        32'd0,        0);

    // reset in the middle of a MULT run
    issue("mult reset",   4'b0010, 3'd1, 32'd5,        32'd5,        32'd0,     1'b0, 2'd0, 2'd0, 5'd13, 32'd10,      32'd5,        0);
    repeat (10) idleCycle();
    setId(4'b0010, 3'd0, 32'd8, 32'd8, 32'd0, 1'b0, 2'd0, 2'd0, 5'd14);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset mid-run", {7'd0, InstrVal_EX, dutWord()}, 80'd0);
    issue("mflo reset",   4'b0010, 3'd6, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd0,        32'd0,        0);
    issue("mfhi reset",   4'b0010, 3'd5, 32'd0,        32'd0,        32'd0,     1'b0, 2'd0, 2'd0, 5'd9, 32'd0,        32'd0,        0);

    idleCycle();
    @(negedge clk);
    #1;
    check("queue drained", 80'(exp_q.size()), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
